// File: rtl/rr_timeout_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin timeout arbiter.
interface rr_timeout_arbiter_if #(
   parameter int N = 4
);
   logic [N-1:0]         req;
   logic [N-1:0]         gnt;
   logic [$clog2(N)-1:0] gnt_id;
   logic                 busy;
   logic                 preempt;

   modport master (
      output req,
      input  gnt,
      input  gnt_id,
      input  busy,
      input  preempt
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_id,
      output busy,
      output preempt
   );
endinterface

// File: rtl/rr_timeout_arbiter.sv
// Round-robin arbiter with hold-limit preemption and a one-cycle turnaround
// gap between owners; every output comes straight from a register.
module rr_timeout_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16
) (
   input logic                clk,
   input logic                reset,
   rr_timeout_arbiter_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
   localparam logic [IW-1:0] LAST_ID  = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nx_s;
   logic [N-1:0]  gnt_r;
   logic [N-1:0]  gnt_nx_s;
   logic [IW-1:0] gnt_id_r;
   logic [IW-1:0] id_nx_s;
   logic [IW-1:0] ptr_r;
   logic [IW-1:0] ptr_nx_s;
   logic [CW-1:0] hold_cnt_r;
   logic [CW-1:0] cnt_nx_s;
   logic          busy_r;
   logic          preempt_r;
   logic          preempt_nx_s;

   logic [IW-1:0] win_s;
   logic          found_s;
   logic          owner_req_s;
   logic          others_s;
   logic          timeout_s;
   logic [IW-1:0] next_ptr_s;

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
      logic [N-1:0] v;
      v = {{(N-1){1'b0}}, 1'b1} << idx;
      return v;
   endfunction

   // Priority scan starting at ptr with wrap; the first asserted request wins.
   always_comb begin
      logic [IW-1:0] idx;
      logic          hit;
      win_s   = {IW{1'b0}};
      found_s = 1'b0;
      idx     = {IW{1'b0}};
      hit     = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx     = IW'((int'(ptr_r) + k) % N);
         hit     = bus.req[idx] & ~found_s;
         win_s   = hit ? idx : win_s;
         found_s = found_s | bus.req[idx];
      end
   end

   // gnt_r is one-hot in GRANT, so masking with it isolates the owner's request.
   assign owner_req_s = |(bus.req & gnt_r);
   assign others_s    = |(bus.req & ~gnt_r);
   assign timeout_s   = (hold_cnt_r == HOLD_MAX) && others_s;
   assign next_ptr_s  = (gnt_id_r == LAST_ID) ? {IW{1'b0}} : (gnt_id_r + IW'(1));

   // Next-state and next-output decode.
   always_comb begin
      state_nx_s   = state_r;
      gnt_nx_s     = gnt_r;
      id_nx_s      = gnt_id_r;
      ptr_nx_s     = ptr_r;
      cnt_nx_s     = hold_cnt_r;
      preempt_nx_s = 1'b0;
      case (state_r)
         IDLE, TURN: begin
            if (found_s) begin
               state_nx_s = GRANT;
               gnt_nx_s   = onehot(win_s);
               id_nx_s    = win_s;
               cnt_nx_s   = CW'(1);
            end else begin
               state_nx_s = IDLE;
               gnt_nx_s   = {N{1'b0}};
            end
         end
         GRANT: begin
            if (!owner_req_s) begin
               state_nx_s = TURN;
               gnt_nx_s   = {N{1'b0}};
               ptr_nx_s   = next_ptr_s;
            end else if (timeout_s) begin
               state_nx_s   = TURN;
               gnt_nx_s     = {N{1'b0}};
               ptr_nx_s     = next_ptr_s;
               preempt_nx_s = 1'b1;
            end else if (hold_cnt_r != HOLD_MAX) begin
               cnt_nx_s = hold_cnt_r + CW'(1);
            end else begin
               cnt_nx_s = hold_cnt_r;
            end
         end
         default: begin
            state_nx_s = IDLE;
            gnt_nx_s   = {N{1'b0}};
            id_nx_s    = {IW{1'b0}};
            ptr_nx_s   = {IW{1'b0}};
            cnt_nx_s   = {CW{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         gnt_r      <= {N{1'b0}};
         gnt_id_r   <= {IW{1'b0}};
         ptr_r      <= {IW{1'b0}};
         hold_cnt_r <= {CW{1'b0}};
         busy_r     <= 1'b0;
         preempt_r  <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         gnt_r      <= gnt_nx_s;
         gnt_id_r   <= id_nx_s;
         ptr_r      <= ptr_nx_s;
         hold_cnt_r <= cnt_nx_s;
         busy_r     <= (state_nx_s == GRANT);
         preempt_r  <= preempt_nx_s;
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.gnt_id  = gnt_id_r;
   assign bus.busy    = busy_r;
   assign bus.preempt = preempt_r;
endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Self-checking bench for rr_timeout_arbiter: vector table, directed corner
// sequences and random traffic against an owner/pointer reference model.
module tb_rr_timeout_arbiter;
   localparam int N    = 4;
   localparam int MAXH = 4;

   logic clk;
   logic reset;
   logic [3:0] rq;

   rr_timeout_arbiter_if #(.N(N)) bus ();

   rr_timeout_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       pre;
   } vec_t;

   vec_t vecs[$];
   int checks = 0;
   int errors = 0;

   // Reference model: owner index (-1 when nobody owns), pointer, hold, last owner.
   int   m_owner = -1;
   int   m_ptr   = 0;
   int   m_hold  = 0;
   int   m_last  = 0;
   logic m_pre   = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (((r >> ((p + k) % N)) & 4'b0001) != 4'b0000) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [3:0] r, input logic rst_v);
      logic [3:0] own;
      int w;
      if (!rst_v) begin
         m_owner = -1; m_ptr = 0; m_hold = 0; m_last = 0; m_pre = 1'b0;
      end else begin
         m_pre = 1'b0;
         if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
               m_owner = w; m_last = w; m_hold = 1;
            end
         end else begin
            own = 4'b0001 << m_owner;
            if ((r & own) == 4'b0000) begin
               m_ptr = (m_owner + 1) % N; m_owner = -1;
            end else if (m_hold >= MAXH && (r & ~own) != 4'b0000) begin
               m_ptr = (m_owner + 1) % N; m_owner = -1; m_pre = 1'b1;
            end else if (m_hold < MAXH) begin
               m_hold = m_hold + 1;
            end
         end
      end
   endtask

   function automatic logic [7:0] model_out();
      logic [3:0] g;
      g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      return {g, 2'(m_last), (m_owner >= 0), m_pre};
   endfunction

   function automatic logic [7:0] dut_out();
      return {bus.gnt, bus.gnt_id, bus.busy, bus.preempt};
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got gnt=%b id=%0d busy=%b preempt=%b, want gnt=%b id=%0d busy=%b preempt=%b",
                  name, got[7:4], got[3:2], got[1], got[0], exp[7:4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   task automatic tick(input logic [3:0] r, input logic rst_v);
      @(negedge clk);
      bus.req = r;
      reset   = rst_v;
      @(posedge clk);
      model_step(r, rst_v);
      #1;
      check("model", dut_out(), model_out());
   endtask

   task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] id, input logic pre);
      check(name, dut_out(), {g, id, (g != 4'b0000), pre});
   endtask

   task automatic add(input logic rst_v, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] id, input logic pre);
      vec_t v;
      v.rst = rst_v; v.req = r; v.gnt = g; v.id = id; v.pre = pre;
      vecs.push_back(v);
   endtask

   initial begin
      reset   = 1'b0;
      bus.req = 4'b0000;
      rq      = 4'b0000;

      // Reset state.
      add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
      add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
      // Round robin by release: two grant cycles, drop, reassert.
      add(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0);
      add(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0);
      add(1'b1, 4'b1110, 4'b0000, 2'd0, 1'b0);
      add(1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0);
      add(1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0);
      add(1'b1, 4'b1101, 4'b0000, 2'd1, 1'b0);
      add(1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0);
      add(1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0);
      add(1'b1, 4'b1011, 4'b0000, 2'd2, 1'b0);
      add(1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0);
      add(1'b1, 4'b1111, 4'b1000, 2'd3, 1'b0);
      add(1'b1, 4'b0111, 4'b0000, 2'd3, 1'b0);
      add(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0);
      // Reset mid-grant, then pointer is back at 0.
      add(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
      add(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
      add(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
      add(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0);
      add(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0);

      foreach (vecs[i]) begin
         tick(vecs[i].req, vecs[i].rst);
         expect_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].pre);
      end

      // Preemption: two contenders alternate every MAXH cycles plus one gap.
      tick(4'b0000, 1'b0);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < MAXH; c++) begin
            tick(4'b0011, 1'b1);
            expect_out("preempt_hold", 4'b0001 << (r % 2), 2'(r % 2), 1'b0);
         end
         tick(4'b0011, 1'b1);
         expect_out("preempt_pulse", 4'b0000, 2'(r % 2), 1'b1);
      end

      // Sole requester keeps the grant, then a newcomer forces preemption.
      tick(4'b0000, 1'b0);
      for (int c = 0; c < 40; c++) begin
         tick(4'b0100, 1'b1);
         expect_out("sole_hold", 4'b0100, 2'd2, 1'b0);
      end
      tick(4'b0101, 1'b1);
      expect_out("sole_preempt", 4'b0000, 2'd2, 1'b1);
      tick(4'b0101, 1'b1);
      expect_out("sole_wrap", 4'b0001, 2'd0, 1'b0);

      // Idle, then a single-cycle request glitch.
      tick(4'b0000, 1'b0);
      for (int c = 0; c < 10; c++) begin
         tick(4'b0000, 1'b1);
         expect_out("idle", 4'b0000, 2'd0, 1'b0);
      end
      tick(4'b1000, 1'b1);
      expect_out("glitch_gnt", 4'b1000, 2'd3, 1'b0);
      tick(4'b0000, 1'b1);
      expect_out("glitch_turn", 4'b0000, 2'd3, 1'b0);
      tick(4'b0000, 1'b1);
      expect_out("glitch_idle", 4'b0000, 2'd3, 1'b0);

      // Random traffic with sticky requests and occasional reset.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
         tick(rq, ($urandom_range(0, 199) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
